// File: rtl/adder_bus_arbiter_pkg.sv
// adder_arb_pkg
// Shared types and width helpers for the adder bus arbiter slice.
//   arb_state_t : arbiter FSM states (TURN is only reachable when the
//                 ADDER_ARB_TURNAROUND_EN macro is defined)
//   ptr_width() : index width for a count of items, never below 1 bit
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  // Width needed to index n items; clamped to 1 so a count of 1 still
  // yields a legal vector.
  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_bus_arbiter_if.sv
// adder_bus_arbiter_if
// Request/grant bundle between the requesting agents and the arbiter.
//   req       : per-requester level request
//   done      : per-requester release pulse (only the owner's bit matters)
//   enable    : one-hot-or-zero output enables to the tri-state adders
//   gnt_id    : index of the current owner, valid while bus_valid
//   bus_valid : an adder is driving the shared bus
//   timeout   : one-cycle pulse when an owner is cut off by the hold limit
// Modports: master = requesting side, slave = arbiter side.
interface adder_bus_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4
);
  localparam int PTR_W = ptr_width(NREQ);

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  done;
  logic [NREQ-1:0]  enable;
  logic [PTR_W-1:0] gnt_id;
  logic             bus_valid;
  logic             timeout;

  modport master (output req, done, input enable, gnt_id, bus_valid, timeout);
  modport slave  (input req, done, output enable, gnt_id, bus_valid, timeout);

endinterface

// File: rtl/adder_bus_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin first-one search.
//   req        : request vector
//   last_owner : most recent owner; search starts just above it and wraps
//   winner     : index of the first requester found (0 when none)
//   any_req    : at least one request is high
module rr_picker
  import adder_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] last_owner,
  output logic [PTR_W-1:0] winner,
  output logic             any_req
);

  logic             found;
  logic [PTR_W-1:0] cand;

  // Walk last_owner+1 .. last_owner+NREQ (mod NREQ); the previous owner
  // is visited last, which makes it the lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PTR_W'((int'(last_owner) + i) % NREQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/adder_bus_arbiter.sv
// adder_bus_arbiter
// Round-robin owner of a shared tri-state sum bus. Drives one-hot-or-zero
// output enables to NREQ adders, limits ownership to MAX_HOLD cycles and
// optionally inserts a dead cycle between owners.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : adder_bus_arbiter_if.slave (req, done in; enable, gnt_id,
//         bus_valid, timeout out)
// Build option: define ADDER_ARB_TURNAROUND_EN to add the TURN state, which
// leaves the bus undriven for one cycle between any two owners.
module adder_bus_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  adder_bus_arbiter_if.slave  bus
);

  localparam int PTR_W  = ptr_width(NREQ);
  localparam int HOLD_W = ptr_width(MAX_HOLD);

  arb_state_t       state;
  logic [PTR_W-1:0] last_owner;
  logic [HOLD_W-1:0] hold_cnt;
  logic [PTR_W-1:0] winner;
  logic             any_req;
  logic             owner_release;
  logic             hold_expired;

  rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_picker (
    .req        (bus.req),
    .last_owner (last_owner),
    .winner     (winner),
    .any_req    (any_req)
  );

  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Voluntary release (done or dropped request) is checked only for the
  // current owner, so stray done pulses from others have no effect.
  assign owner_release = bus.done[bus.gnt_id] || !bus.req[bus.gnt_id];
  assign hold_expired  = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign bus.bus_valid = |bus.enable;

  // Main FSM. enable, gnt_id and timeout are all registered so the adders
  // never see a combinational glitch on their output enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus.enable  <= '0;
      bus.gnt_id  <= '0;
      bus.timeout <= 1'b0;
      last_owner  <= PTR_W'(NREQ - 1);
      hold_cnt    <= '0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
`ifdef ADDER_ARB_TURNAROUND_EN
        IDLE, TURN: begin
`else
        IDLE: begin
`endif
          if (any_req) begin
            bus.enable <= onehot(winner);
            bus.gnt_id <= winner;
            last_owner <= winner;
            hold_cnt   <= '0;
            state      <= OWN;
          end else begin
            bus.enable <= '0;
            state      <= IDLE;
          end
        end

        OWN: begin
          if (owner_release || hold_expired) begin
            // A voluntary release in the same cycle as expiry is not a
            // timeout.
            bus.timeout <= !owner_release;
            hold_cnt    <= '0;
`ifdef ADDER_ARB_TURNAROUND_EN
            bus.enable  <= '0;
            state       <= TURN;
`else
            if (any_req) begin
              bus.enable <= onehot(winner);
              bus.gnt_id <= winner;
              last_owner <= winner;
              state      <= OWN;
            end else begin
              bus.enable <= '0;
              state      <= IDLE;
            end
`endif
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: begin
          bus.enable <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
